// File: rtl/serial_frame_router_pkg.sv
// Shared definitions for serial_frame_router: state encoding, parameter defaults
// and the start pattern the frame detector searches for.
package serial_frame_router_pkg;

    typedef enum logic [2:0] {
        SEARCH  = 3'd0,
        ADDR    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_NUM_CH = 4;

    // Sent MSB first on the serial line.
    localparam int                   START_LEN     = 7;
    localparam logic [START_LEN-1:0] START_PATTERN = 7'b0111110;

    function automatic logic even_parity_step(input logic acc, input logic b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/serial_frame_router_if.sv
// Serial-side and channel-side signals of serial_frame_router; the router uses
// the slave modport, whoever drives the line and consumes channels uses master.
interface serial_frame_router_if
    import serial_frame_router_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    logic              serIn;
    logic              serOut;
    logic [NUM_CH-1:0] chValid;
    logic              busy;
    logic              done;
    logic              err;
    logic [LEN_W-1:0]  lenRemaining;

    modport master (
        output serIn,
        input  serOut, chValid, busy, done, err, lenRemaining
    );

    modport slave (
        input  serIn,
        output serOut, chValid, busy, done, err, lenRemaining
    );
endinterface

// File: rtl/serial_frame_router_detector.sv
// start_pattern_detector: Mealy matcher for START_PATTERN; w is high in the
// cycle the final pattern bit is present on serIn.
module start_pattern_detector
    import serial_frame_router_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic serIn,
    output logic w
);
    localparam logic [2:0] LAST = 3'(START_LEN - 1);

    logic [2:0] match_q, match_d;

    // Number of pattern bits matched so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 3'd0;
        end else begin
            match_q <= match_d;
        end
    end

    // On a mismatch the only prefix that can survive is the single leading bit,
    // because the pattern's inner run of ones never re-aligns with its start.
    always_comb begin
        w       = 1'b0;
        match_d = match_q;
        if (serIn == START_PATTERN[START_LEN - 1 - int'(match_q)]) begin
            if (match_q == LAST) begin
                w       = 1'b1;
                match_d = (serIn == START_PATTERN[START_LEN-1]) ? 3'd1 : 3'd0;
            end else begin
                match_d = match_q + 3'd1;
            end
        end else begin
            match_d = (serIn == START_PATTERN[START_LEN-1]) ? 3'd1 : 3'd0;
        end
    end
endmodule

// File: rtl/serial_frame_router.sv
// serial_frame_router: finds a start pattern, then shifts in address and length
// and routes the payload to one channel. Define PARITY_CHECK_EN for a trailing parity bit.
module serial_frame_router
    import serial_frame_router_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int NUM_CH = DEF_NUM_CH
)(
    input  logic                 clk,
    input  logic                 rst,
    serial_frame_router_if.slave bus
);
    localparam int               CNT_W     = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
`ifdef PARITY_CHECK_EN
    localparam state_t FRAME_TAIL = PARITY;
`else
    localparam state_t FRAME_TAIL = DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              det_rst_s;
    logic              flag_s;
`ifdef PARITY_CHECK_EN
    logic              par_q, par_d;
    logic              err_q, err_d;
`endif

    // Keeping the detector in reset outside SEARCH stops payload bits from retriggering it.
    assign det_rst_s = rst | (state_q != SEARCH);

    start_pattern_detector u_detector (
        .clk   (clk),
        .rst   (det_rst_s),
        .serIn (bus.serIn),
        .w     (flag_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_CHECK_EN
            par_q   <= par_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and datapath update; len_q doubles as the payload down-counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifdef PARITY_CHECK_EN
        par_d   = par_q;
        err_d   = err_q;
`endif
        case (state_q)
            SEARCH: begin
                cnt_d = '0;
`ifdef PARITY_CHECK_EN
                par_d = 1'b0;
                err_d = 1'b0;
`endif
                if (flag_s) begin
                    state_d = ADDR;
                end else begin
                    state_d = SEARCH;
                end
            end
            ADDR: begin
                addr_d = ADDR_W'({addr_q, bus.serIn});
                if (cnt_q == ADDR_LAST) begin
                    cnt_d   = '0;
                    state_d = LEN;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                end
            end
            LEN: begin
                len_d = LEN_W'({len_q, bus.serIn});
                if (cnt_q == LEN_LAST) begin
                    cnt_d = '0;
                    if (len_d != '0) begin
                        state_d = PAYLOAD;
                    end else begin
                        state_d = FRAME_TAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1'b1);
                end
            end
            PAYLOAD: begin
                len_d = len_q - LEN_W'(1'b1);
`ifdef PARITY_CHECK_EN
                par_d = even_parity_step(par_q, bus.serIn);
`endif
                if (len_q == LEN_W'(1'b1)) begin
                    state_d = FRAME_TAIL;
                end else begin
                    state_d = PAYLOAD;
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                err_d   = bus.serIn ^ par_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = SEARCH;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // Output decode from the current state; serOut follows serIn combinationally.
    always_comb begin
        bus.busy = (state_q != SEARCH);
        bus.done = (state_q == DONE);
        if (state_q == PAYLOAD) begin
            bus.chValid      = NUM_CH'(1'b1) << addr_q;
            bus.serOut       = bus.serIn;
            bus.lenRemaining = len_q;
        end else begin
            bus.chValid      = '0;
            bus.serOut       = 1'b0;
            bus.lenRemaining = '0;
        end
`ifdef PARITY_CHECK_EN
        if (state_q == DONE) begin
            bus.err = err_q;
        end else begin
            bus.err = 1'b0;
        end
`else
        bus.err = 1'b0;
`endif
    end
endmodule

// File: tb/tb_serial_frame_router.sv
// Directed bench for serial_frame_router: inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_serial_frame_router;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    serial_frame_router_if #(.ADDR_W(2), .LEN_W(4), .NUM_CH(4)) bus ();

    serial_frame_router #(.ADDR_W(2), .LEN_W(4), .NUM_CH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b);
        @(negedge clk);
        bus.serIn = b;
        #1;
    endtask

    // One complete frame; pay[i] is the i-th payload bit on the line.
    task automatic frame(input logic [1:0] a, input logic [3:0] l, input logic [14:0] pay,
                         input logic pbit, input logic [3:0] exp_ch, input logic exp_err);
        logic [6:0] sp;
        sp = 7'b0111110;
        for (int k = 6; k >= 0; k--) begin
            drive(sp[k]);
            chk("search", {bus.busy, bus.done, bus.chValid, bus.serOut}, 32'h0);
        end
        for (int k = 1; k >= 0; k--) begin
            drive(a[k]);
            chk("addr", {bus.busy, bus.done, bus.chValid, bus.serOut, bus.lenRemaining}, 32'h400);
        end
        for (int k = 3; k >= 0; k--) begin
            drive(l[k]);
            chk("len", {bus.busy, bus.done, bus.chValid, bus.serOut, bus.lenRemaining}, 32'h400);
        end
        for (int i = 0; i < int'(l); i++) begin
            drive(pay[i]);
            chk("pay_ch", {28'h0, bus.chValid}, {28'h0, exp_ch});
            chk("pay_ser", {31'h0, bus.serOut}, {31'h0, pay[i]});
            chk("pay_rem", {28'h0, bus.lenRemaining}, 32'(int'(l) - i));
            chk("pay_done", {31'h0, bus.done}, 32'h0);
        end
`ifdef PARITY_CHECK_EN
        drive(pbit);
        chk("parity", {bus.busy, bus.done, bus.chValid}, 32'h20);
`else
        if (pbit) begin
        end
`endif
        drive(1'b1);
        chk("done", {31'h0, bus.done}, 32'h1);
        chk("done_busy", {31'h0, bus.busy}, 32'h1);
        chk("done_ch", {28'h0, bus.chValid}, 32'h0);
`ifdef PARITY_CHECK_EN
        chk("err", {31'h0, bus.err}, {31'h0, exp_err});
`else
        chk("err", {31'h0, bus.err}, {31'h0, 1'b0 & exp_err});
`endif
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        bus.serIn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", {bus.busy, bus.done, bus.err, bus.chValid, bus.serOut, bus.lenRemaining}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0);
        drive(1'b0);

        // Basic frame, then a zero-length frame starting right after DONE.
        frame(2'b10, 4'd3, 15'b101, 1'b0, 4'b0100, 1'b0);
        frame(2'b01, 4'd0, 15'b0, 1'b0, 4'b0010, 1'b0);
        // Start pattern embedded in a maximum-length payload (9 ones, parity 1).
        frame(2'b11, 4'd15, 15'b011001010111110, 1'b1, 4'b1000, 1'b0);
        // Wrong parity bit for payload 101.
        frame(2'b10, 4'd3, 15'b101, 1'b1, 4'b0100, 1'b1);
        drive(1'b0);
        chk("post_done", {bus.busy, bus.done, bus.err}, 32'h0);

        // Reset in the second payload cycle of addr 01, len 4.
        for (int k = 0; k < 13; k++) begin
            logic [12:0] hdr;
            hdr = 13'b0111110_01_0100;
            drive(hdr[12-k]);
        end
        drive(1'b1);
        chk("mid_ch1", {28'h0, bus.chValid}, 32'h2);
        drive(1'b1);
        chk("mid_rem2", {28'h0, bus.lenRemaining}, 32'h3);
        rst = 1'b1;
        #1;
        chk("mid_rst", {bus.busy, bus.done, bus.err, bus.chValid, bus.serOut, bus.lenRemaining}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1);
            chk("mid_drop", {bus.busy, bus.done, bus.chValid}, 32'h0);
        end
        frame(2'b00, 4'd2, 15'b11, 1'b0, 4'b0001, 1'b0);
        drive(1'b0);
        chk("end_idle", {bus.busy, bus.done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
